// File: rtl/bsg_inv_pkg.sv
// rtl/bsg_inv_pkg.sv - shared constants for the masked inverter pipeline
//
// Purpose: constants shared by bsg_inv_masked_pipe, its interface and its
// stage register. No ports.
package bsg_inv_pkg;

  // Extra payload bits carried per stage next to the data word.
`ifdef BSG_INV_MASKED_PIPE_PARITY_EN
  localparam int parity_bits_c = 1;
`else
  localparam int parity_bits_c = 0;
`endif

  // Replicated across the mask width at reset; all ones means full inversion.
  localparam logic mask_reset_bit_c = 1'b1;

endpackage

// File: rtl/bsg_inv_masked_pipe_if.sv
// rtl/bsg_inv_masked_pipe_if.sv - stream, mask and counter bundle for bsg_inv_masked_pipe
//
// Purpose: groups the mask-write, ingress stream, egress stream and counter
// signals of bsg_inv_masked_pipe.
// Signals:
//   mask_v_i / mask_i  : mask write strobe and new mask
//   mask_o             : current mask
//   v_i / data_i       : ingress beat, ready_o accepts it
//   v_o / data_o       : egress beat, consumed by yumi_i
//   count_o            : delivered-beat counter
//   parity_o           : even parity of data_o (BSG_INV_MASKED_PIPE_PARITY_EN only)
// Modports: slave = the pipeline, master = the block driving it.
interface bsg_inv_masked_pipe_if #(
  parameter int width_p       = 32,
  parameter int count_width_p = 16
);

  logic                     mask_v_i;
  logic [width_p-1:0]       mask_i;
  logic [width_p-1:0]       mask_o;
  logic                     v_i;
  logic [width_p-1:0]       data_i;
  logic                     ready_o;
  logic                     v_o;
  logic [width_p-1:0]       data_o;
  logic                     yumi_i;
  logic [count_width_p-1:0] count_o;
`ifdef BSG_INV_MASKED_PIPE_PARITY_EN
  logic                     parity_o;
`endif

  modport slave (
    input  mask_v_i, mask_i, v_i, data_i, yumi_i,
    output mask_o, ready_o, v_o, data_o, count_o
`ifdef BSG_INV_MASKED_PIPE_PARITY_EN
    , output parity_o
`endif
  );

  modport master (
    output mask_v_i, mask_i, v_i, data_i, yumi_i,
    input  mask_o, ready_o, v_o, data_o, count_o
`ifdef BSG_INV_MASKED_PIPE_PARITY_EN
    , input parity_o
`endif
  );

endinterface

// File: rtl/bsg_inv_pipe_stage.sv
// rtl/bsg_inv_pipe_stage.sv - one valid/payload pipeline register with load enable
//
// Purpose: single stage of the masked inverter pipeline.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset (clears valid and payload)
//   en_i             : load v_i/data_i this cycle
//   v_i, data_i      : incoming valid and payload
//   v_o, data_o      : registered valid and payload
module bsg_inv_pipe_stage #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o
);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_o    <= 1'b0;
      data_o <= '0;
    end else if (en_i) begin
      v_o    <= v_i;
      data_o <= data_i;
    end
  end

endmodule

// File: rtl/bsg_inv_masked_pipe.sv
// rtl/bsg_inv_masked_pipe.sv - pipelined programmable per-bit inverter with beat counter
//
// Purpose: XORs each accepted beat with a run-time mask at ingress, carries it
// through stages_p bubble-compressing register stages and counts delivered beats.
// Optional macro BSG_INV_MASKED_PIPE_PARITY_EN adds io.parity_o, the even parity
// of the post-mask word, carried alongside the data.
// Ports:
//   clk_i     : clock
//   reset_n_i : asynchronous active-low reset
//   io        : bsg_inv_masked_pipe_if.slave (mask write, ingress/egress streams, counter)
module bsg_inv_masked_pipe
  import bsg_inv_pkg::*;
#(
  parameter int                 width_p       = 32,
  parameter int                 stages_p      = 2,
  parameter logic [width_p-1:0] mask_reset_p  = {width_p{mask_reset_bit_c}},
  parameter int                 count_width_p = 16
) (
  input logic                  clk_i,
  input logic                  reset_n_i,
  bsg_inv_masked_pipe_if.slave io
);

  localparam int payload_w_lp = width_p + parity_bits_c;

  typedef struct packed {
    logic                    v;
    logic [payload_w_lp-1:0] payload;
  } stage_s;

  logic [width_p-1:0]       mask_r;
  logic [count_width_p-1:0] count_r;
  logic [width_p-1:0]       ingress_data;
  logic [payload_w_lp-1:0]  ingress_payload;
  logic [stages_p-1:0]      adv;
  stage_s                   st_q [stages_p];

  // Mask applied at ingress only; in-flight beats keep the mask they entered with.
  assign ingress_data = io.data_i ^ mask_r;

`ifdef BSG_INV_MASKED_PIPE_PARITY_EN
  assign ingress_payload = {^ingress_data, ingress_data};
`else
  assign ingress_payload = ingress_data;
`endif

  // Stage k may load when it or any stage downstream of it is empty, or the
  // output is being consumed. Folded from the output end with a running term
  // so the advance vector never feeds itself.
  always_comb begin
    logic run;
    adv = '0;
    run = io.yumi_i;
    for (int k = stages_p - 1; k >= 0; k--) begin
      run    = ~st_q[k].v | run;
      adv[k] = run;
    end
  end

  for (genvar k = 0; k < stages_p; k++) begin : g_stage
    logic                    in_v;
    logic [payload_w_lp-1:0] in_payload;

    if (k == 0) begin : g_head
      assign in_v       = io.v_i;
      assign in_payload = ingress_payload;
    end else begin : g_body
      assign in_v       = st_q[k-1].v;
      assign in_payload = st_q[k-1].payload;
    end

    bsg_inv_pipe_stage #(
      .width_p (payload_w_lp)
    ) stage (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .en_i      (adv[k]),
      .v_i       (in_v),
      .data_i    (in_payload),
      .v_o       (st_q[k].v),
      .data_o    (st_q[k].payload)
    );
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mask_r <= mask_reset_p;
    end else if (io.mask_v_i) begin
      mask_r <= io.mask_i;
    end
  end

  // Gated by v_o so an illegal yumi_i on an empty output never counts.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= '0;
    end else if (io.yumi_i && io.v_o) begin
      count_r <= count_r + count_width_p'(1);
    end
  end

  assign io.ready_o = adv[0];
  assign io.v_o     = st_q[stages_p-1].v;
  assign io.data_o  = st_q[stages_p-1].payload[width_p-1:0];
  assign io.mask_o  = mask_r;
  assign io.count_o = count_r;

`ifdef BSG_INV_MASKED_PIPE_PARITY_EN
  assign io.parity_o = st_q[stages_p-1].payload[width_p];
`endif

  yumi_needs_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) !(io.yumi_i && !io.v_o)
  );

endmodule
